// File: rtl/dice_result_filter_pkg.sv
// Shared types and default constants for the dice result filter: colour
// classes, the acceptance FSM states and the default tuning values.
package dice_pkg;

    typedef enum logic [1:0] {
        BG = 2'd0,
        C1 = 2'd1,
        C2 = 2'd2,
        C3 = 2'd3
    } color_t;

    typedef enum logic [1:0] {
        S_SEARCH  = 2'd0,
        S_FIRE    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    localparam int STABLE_FRAMES_DEF  = 8;
    localparam int MIN_PIXELS_DEF     = 2000;
    localparam int RELEASE_FRAMES_DEF = 4;
    localparam int CNT_W_DEF          = 17;

endpackage

// File: rtl/dice_result_filter_if.sv
// Pixel-stream input and roll-result output bundle between the vision
// front end (master) and the dice result filter (slave).
interface dice_result_filter_if;
    import dice_pkg::*;

    logic       frame_start;
    logic       pixel_valid;
    logic [1:0] pixel_class;
    logic       frame_end;
    logic       dice_valid;
    logic [1:0] dice_value;
    logic [1:0] frame_color;
    logic       armed;

    modport master (
        output frame_start, pixel_valid, pixel_class, frame_end,
        input  dice_valid, dice_value, frame_color, armed
    );

    modport slave (
        input  frame_start, pixel_valid, pixel_class, frame_end,
        output dice_valid, dice_value, frame_color, armed
    );

endinterface

// File: rtl/frame_color_counter.sv
// Per-frame pixel counting for classes 1..3 and the argmax that names the
// winning colour of each frame (BG when the winner is below MIN_PIXELS).
module frame_color_counter
    import dice_pkg::*;
#(
    parameter int MIN_PIXELS = MIN_PIXELS_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_frame_start,
    input  logic       i_pixel_valid,
    input  logic [1:0] i_pixel_class,
    input  logic       i_frame_end,
    output color_t     o_frame_color,
    output logic       o_color_vld
);

    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_PIXELS);

    logic [CNT_W-1:0] r_cnt_p0 [3];
    logic [CNT_W-1:0] w_cnt_nxt [3];
    color_t           r_color_p1;
    logic             r_vld_p1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        if (inc && (v != {CNT_W{1'b1}}))
            return v + CNT_W'(1);
        return v;
    endfunction

    // Ties keep the lower class because only a strictly larger count wins.
    function automatic color_t pick_winner(input logic [CNT_W-1:0] c1,
                                           input logic [CNT_W-1:0] c2,
                                           input logic [CNT_W-1:0] c3);
        logic [CNT_W-1:0] best;
        color_t           col;
        best = c1;
        col  = C1;
        if (c2 > best) begin
            best = c2;
            col  = C2;
        end
        if (c3 > best) begin
            best = c3;
            col  = C3;
        end
        if (best < MIN_C)
            col = BG;
        return col;
    endfunction

    // Stage p0: a frame_start clears the count but still admits its own pixel.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            w_cnt_nxt[k] = sat_inc(i_frame_start ? '0 : r_cnt_p0[k],
                                   i_pixel_valid && (i_pixel_class == 2'(k + 1)));
        end
    end

    // Stage p1: evaluate the counts including the frame_end pixel, then clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 3; k++) r_cnt_p0[k] <= '0;
            r_color_p1 <= BG;
            r_vld_p1   <= 1'b0;
        end else begin
            r_vld_p1 <= i_frame_end;
            if (i_frame_end) begin
                for (int k = 0; k < 3; k++) r_cnt_p0[k] <= '0;
                r_color_p1 <= pick_winner(w_cnt_nxt[0], w_cnt_nxt[1], w_cnt_nxt[2]);
            end else begin
                for (int k = 0; k < 3; k++) r_cnt_p0[k] <= w_cnt_nxt[k];
            end
        end
    end

    assign o_frame_color = r_color_p1;
    assign o_color_vld   = r_vld_p1;

endmodule

// File: rtl/dice_result_filter.sv
// Accepts a dice roll once the same frame colour persists for STABLE_FRAMES
// frames, fires one pulse, then waits for RELEASE_FRAMES empty frames to re-arm.
module dice_result_filter
    import dice_pkg::*;
#(
    parameter int STABLE_FRAMES  = STABLE_FRAMES_DEF,
    parameter int MIN_PIXELS     = MIN_PIXELS_DEF,
    parameter int RELEASE_FRAMES = RELEASE_FRAMES_DEF,
    parameter int CNT_W          = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    dice_result_filter_if.slave  bus
);

    localparam int               RUN_W    = $clog2(STABLE_FRAMES + 1);
    localparam int               REL_W    = $clog2(RELEASE_FRAMES + 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(STABLE_FRAMES);
    localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_FRAMES - 1);

    color_t           w_fc;
    logic             w_fc_vld;
    state_t           r_state,       w_state_nxt;
    logic [RUN_W-1:0] r_run_p2,      w_run_nxt;
    color_t           r_cand_p2,     w_cand_nxt;
    logic [REL_W-1:0] r_rel_p2,      w_rel_nxt;
    color_t           r_dice_value,  w_dice_value_nxt;

    frame_color_counter #(
        .MIN_PIXELS (MIN_PIXELS),
        .CNT_W      (CNT_W)
    ) u_counter (
        .clk           (clk),
        .reset         (reset),
        .i_frame_start (bus.frame_start),
        .i_pixel_valid (bus.pixel_valid),
        .i_pixel_class (bus.pixel_class),
        .i_frame_end   (bus.frame_end),
        .o_frame_color (w_fc),
        .o_color_vld   (w_fc_vld)
    );

    // Stage p2: run tracking only moves while searching; a full run freezes it.
    always_comb begin
        w_state_nxt      = r_state;
        w_run_nxt        = r_run_p2;
        w_cand_nxt       = r_cand_p2;
        w_rel_nxt        = r_rel_p2;
        w_dice_value_nxt = r_dice_value;
        case (r_state)
            S_SEARCH: begin
                if (r_run_p2 == RUN_MAX) begin
                    w_state_nxt      = S_FIRE;
                    w_dice_value_nxt = r_cand_p2;
                end else if (w_fc_vld) begin
                    if (w_fc == BG) begin
                        w_run_nxt = '0;
                    end else if (w_fc == r_cand_p2) begin
                        w_run_nxt = r_run_p2 + RUN_W'(1);
                    end else begin
                        w_cand_nxt = w_fc;
                        w_run_nxt  = RUN_W'(1);
                    end
                end
            end
            S_FIRE: begin
                w_state_nxt = S_RELEASE;
                w_rel_nxt   = '0;
            end
            S_RELEASE: begin
                if (w_fc_vld) begin
                    if (w_fc != BG) begin
                        w_rel_nxt = '0;
                    end else if (r_rel_p2 == REL_LAST) begin
                        w_rel_nxt   = '0;
                        w_run_nxt   = '0;
                        w_cand_nxt  = BG;
                        w_state_nxt = S_SEARCH;
                    end else begin
                        w_rel_nxt = r_rel_p2 + REL_W'(1);
                    end
                end
            end
            default: w_state_nxt = S_SEARCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_SEARCH;
            r_run_p2     <= '0;
            r_cand_p2    <= BG;
            r_rel_p2     <= '0;
            r_dice_value <= BG;
        end else begin
            r_state      <= w_state_nxt;
            r_run_p2     <= w_run_nxt;
            r_cand_p2    <= w_cand_nxt;
            r_rel_p2     <= w_rel_nxt;
            r_dice_value <= w_dice_value_nxt;
        end
    end

    assign bus.dice_valid  = (r_state == S_FIRE);
    assign bus.dice_value  = r_dice_value;
    assign bus.frame_color = w_fc;
    assign bus.armed       = (r_state == S_SEARCH);

endmodule

// File: tb/tb_dice_result_filter.sv
// Directed bench: a default-parameter instance for the pixel-threshold cases and
// a small-frame instance (MIN_PIXELS=16, CNT_W=5) for long frame sequences.
module tb_dice_result_filter;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   np[2] = '{0, 0};
    int   pcyc[2] = '{0, 0};
    int   pval[2] = '{0, 0};
    int   fe_cyc[2] = '{0, 0};

    dice_result_filter_if bd();
    dice_result_filter_if bs();

    dice_result_filter u_dut_d (
        .clk   (clk),
        .reset (reset),
        .bus   (bd.slave)
    );

    dice_result_filter #(
        .STABLE_FRAMES  (8),
        .MIN_PIXELS     (16),
        .RELEASE_FRAMES (4),
        .CNT_W          (5)
    ) u_dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (bs.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bd.dice_valid === 1'b1) begin
            np[0]++;
            pcyc[0] = cyc;
            pval[0] = int'(bd.dice_value);
        end
        if (bs.dice_valid === 1'b1) begin
            np[1]++;
            pcyc[1] = cyc;
            pval[1] = int'(bs.dice_value);
        end
    end

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drv(input bit sel, input logic fs, input logic pv,
                       input logic [1:0] pc, input logic fe);
        if (sel) begin
            bs.frame_start = fs; bs.pixel_valid = pv; bs.pixel_class = pc; bs.frame_end = fe;
        end else begin
            bd.frame_start = fs; bd.pixel_valid = pv; bd.pixel_class = pc; bd.frame_end = fe;
        end
        @(posedge clk);
        #1;
    endtask

    // na pixels of class ca then nb pixels of class cb; first on frame_start, last on frame_end.
    task automatic frame(input bit sel, input logic [1:0] ca, input int na,
                         input logic [1:0] cb, input int nb);
        int tot;
        tot = na + nb;
        if (tot == 0) begin
            drv(sel, 1'b1, 1'b0, 2'd0, 1'b0);
            fe_cyc[sel] = cyc;
            drv(sel, 1'b0, 1'b0, 2'd0, 1'b1);
        end else begin
            for (int i = 0; i < tot; i++) begin
                if (i == tot - 1) fe_cyc[sel] = cyc;
                drv(sel, i == 0, 1'b1, (i < na) ? ca : cb, i == tot - 1);
            end
        end
        repeat (4) drv(sel, 1'b0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic frames(input bit sel, input logic [1:0] c, input int n, input int count);
        for (int f = 0; f < count; f++) frame(sel, c, n, 2'd0, 0);
    endtask

    initial begin
        reset = 1'b1;
        bd.frame_start = 1'b0; bd.pixel_valid = 1'b0; bd.pixel_class = 2'd0; bd.frame_end = 1'b0;
        bs.frame_start = 1'b0; bs.pixel_valid = 1'b0; bs.pixel_class = 2'd0; bs.frame_end = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check_val("rst_valid", int'(bd.dice_valid), 0);
        check_val("rst_value", int'(bd.dice_value), 0);
        check_val("rst_color", int'(bd.frame_color), 0);
        check_val("rst_armed", int'(bd.armed), 1);

        frame(1'b0, 2'd1, 1999, 2'd0, 0);
        check_val("min_1999", int'(bd.frame_color), 0);
        frame(1'b0, 2'd1, 2000, 2'd0, 0);
        check_val("min_2000", int'(bd.frame_color), 1);
        frame(1'b0, 2'd1, 2500, 2'd2, 2500);
        check_val("tie_c1_c2", int'(bd.frame_color), 1);

        frames(1'b0, 2'd2, 3000, 7);
        check_val("c2_no_early", np[0], 0);
        frame(1'b0, 2'd2, 3000, 2'd0, 0);
        check_val("c2_pulses", np[0], 1);
        check_val("c2_value", pval[0], 2);
        check_val("c2_latency", pcyc[0] - fe_cyc[0], 3);
        check_val("c2_disarmed", int'(bd.armed), 0);

        frames(1'b0, 2'd0, 0, 4);
        check_val("d_rearmed", int'(bd.armed), 1);
        frames(1'b0, 2'd2, 2000, 7);
        drv(1'b0, 1'b1, 1'b1, 2'd2, 1'b0);
        repeat (999) drv(1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
        reset = 1'b1;
        repeat (3) drv(1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
        reset = 1'b0;
        repeat (10) drv(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        check_val("abort_pulses", np[0], 1);
        check_val("abort_valid", int'(bd.dice_valid), 0);
        check_val("abort_value", int'(bd.dice_value), 0);
        check_val("abort_color", int'(bd.frame_color), 0);
        check_val("abort_armed", int'(bd.armed), 1);
        frame(1'b0, 2'd3, 2000, 2'd0, 0);
        check_val("resume_color", int'(bd.frame_color), 3);

        frame(1'b1, 2'd1, 40, 2'd2, 31);
        check_val("saturate_tie", int'(bs.frame_color), 1);
        drv(1'b1, 1'b1, 1'b1, 2'd3, 1'b0);
        repeat (19) drv(1'b1, 1'b0, 1'b1, 2'd3, 1'b0);
        frame(1'b1, 2'd2, 17, 2'd0, 0);
        check_val("restart", int'(bs.frame_color), 2);
        for (int i = 0; i < 17; i++) drv(1'b1, 1'b0, 1'b1, 2'd1, i == 16);
        repeat (4) drv(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        check_val("no_start", int'(bs.frame_color), 1);
        frame(1'b1, 2'd3, 16, 2'd0, 0);
        check_val("edge_pixels", int'(bs.frame_color), 3);
        frame(1'b1, 2'd0, 0, 2'd0, 0);
        check_val("bg_frame", int'(bs.frame_color), 0);

        frames(1'b1, 2'd3, 20, 7);
        frames(1'b1, 2'd1, 20, 7);
        check_val("switch_no_early", np[1], 0);
        frame(1'b1, 2'd1, 20, 2'd0, 0);
        check_val("switch_pulses", np[1], 1);
        check_val("switch_value", pval[1], 1);
        check_val("switch_latency", pcyc[1] - fe_cyc[1], 3);
        frame(1'b1, 2'd1, 20, 2'd0, 0);
        check_val("switch_once", np[1], 1);

        frames(1'b1, 2'd2, 20, 20);
        check_val("hold_pulses", np[1], 1);
        check_val("hold_color", int'(bs.frame_color), 2);
        check_val("hold_disarmed", int'(bs.armed), 0);
        frames(1'b1, 2'd0, 0, 3);
        check_val("rel3_disarmed", int'(bs.armed), 0);
        frame(1'b1, 2'd0, 0, 2'd0, 0);
        check_val("rel4_armed", int'(bs.armed), 1);
        frames(1'b1, 2'd3, 20, 7);
        check_val("c3_no_early", np[1], 1);
        frame(1'b1, 2'd3, 20, 2'd0, 0);
        check_val("c3_pulses", np[1], 2);
        check_val("c3_value", pval[1], 3);
        check_val("c3_latency", pcyc[1] - fe_cyc[1], 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dice_result_filter.md
DICE_RESULT_FILTER -- requirements
Module: dice_result_filter

Interface
REQ-001 Parameter STABLE_FRAMES, default 8: consecutive identical frame results required to accept a roll.
REQ-002 Parameter MIN_PIXELS, default 2000: minimum winning-class pixel count for a frame to count as non-background.
REQ-003 Parameter RELEASE_FRAMES, default 4: consecutive background frames required to re-arm after a roll.
REQ-004 Parameter CNT_W, default 17: pixel counter width (covers 320x240).
REQ-005 clk  input  1  system clock; all logic on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 frame_start  input  1  one-cycle pulse at the first pixel of a frame.
REQ-008 pixel_valid  input  1  pixel_class is valid this cycle.
REQ-009 pixel_class  input  2  0 = background, 1..3 = dice colour classes.
REQ-010 frame_end  input  1  one-cycle pulse after or with the last pixel of a frame.
REQ-011 dice_valid  output  1  one-cycle pulse: accepted roll; drives game_logic dice_valid.
REQ-012 dice_value  output  2  accepted roll value 1..3; valid while dice_valid is high, held afterwards.
REQ-013 frame_color  output  2  registered winner of the last evaluated frame (0 = none).
REQ-014 armed  output  1  high while in S_SEARCH.

Function
REQ-015 Three saturating counters (classes 1..3) SHALL count pixels with pixel_valid high; class 0 is not counted.
REQ-016 frame_start SHALL clear all counters; a pixel on the same cycle SHALL be counted, giving count 1.
REQ-017 A pixel on the frame_end cycle SHALL be included in that frame's evaluation.
REQ-018 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-019 On the cycle after frame_end, frame_color SHALL update to the class with the maximum count; ties go to the lower class index.
REQ-020 If the maximum count is < MIN_PIXELS, frame_color SHALL be 0; a count equal to MIN_PIXELS qualifies.
REQ-021 frame_end without a preceding frame_start SHALL evaluate the counts accumulated since the last clear.
REQ-022 The counters SHALL clear on the cycle after frame_end.
REQ-023 A frame_start arriving before frame_end SHALL restart the frame; the partial counts are discarded.
REQ-024 Stability tracking SHALL keep a candidate colour and a run count in range 0..STABLE_FRAMES, updated one cycle after frame_color updates.
REQ-025 Run update: a nonzero result equal to the candidate increments the run; a different nonzero result sets candidate = result and run = 1; a 0 result sets run = 0.
REQ-026 FSM state S_SEARCH: when the run reaches STABLE_FRAMES, go to S_FIRE.
REQ-027 FSM state S_FIRE: assert dice_valid for exactly one cycle with dice_value = candidate, then go to S_RELEASE.
REQ-028 Latency: dice_valid SHALL assert exactly 3 cycles after the frame_end of the qualifying frame.
REQ-029 FSM state S_RELEASE: count consecutive frames with frame_color 0; any nonzero frame resets this count.
REQ-030 In S_RELEASE, reaching RELEASE_FRAMES SHALL clear the run and the candidate, then go to S_SEARCH.
REQ-031 No dice_valid SHALL occur outside S_FIRE.
REQ-032 Frame results arriving while in S_FIRE or S_RELEASE SHALL NOT advance the run.

Reset
REQ-033 On reset: state = S_SEARCH, all counters = 0, candidate = 0, run = 0, release count = 0, dice_valid = 0, dice_value = 0, frame_color = 0, armed = 1.
REQ-034 Reset asserted mid-frame or in S_FIRE SHALL abort with no dice_valid pulse; normal operation resumes at the next frame_start.

Structure
REQ-035 Package dice_pkg SHALL hold the colour-class typedef (BG, C1, C2, C3), the FSM state typedef, and default parameter constants.
REQ-036 Per-frame counting and the argmax SHALL live in sub-module frame_color_counter; stability tracking and the FSM stay in dice_result_filter.

Verification (STABLE_FRAMES=8, MIN_PIXELS=2000, RELEASE_FRAMES=4)
REQ-037 Eight frames, each with 3000 class-2 pixels -> one dice_valid pulse, dice_value = 2, exactly 3 cycles after the 8th frame_end.
REQ-038 Seven class-3 frames, then one class-1 frame, then eight class-1 frames -> no pulse until the 8th consecutive class-1 frame, then dice_value = 1.
REQ-039 After a roll, 20 more class-2 frames -> no pulse; then 4 background frames and 8 class-3 frames -> exactly one pulse, dice_value = 3.
REQ-040 A frame with 1999 class-1 pixels -> frame_color = 0; 2000 pixels -> frame_color = 1.
REQ-041 Class-1 and class-2 both at 2500 pixels -> frame_color = 1.
REQ-042 Reset asserted during the 8th qualifying frame -> no dice_valid pulse, and all outputs at their reset values.
